// File: rtl/i2c_arbiter.sv
// Two-requester front end for a single I2C master: detects request edges, arbitrates
// round-robin on ties, forwards one transaction at a time and returns read data/status.
module i2c_arbiter #(
  parameter int MaxBytesToSend     = 16,
  parameter int MaxBytesToRead     = 16,
  parameter int CountWidth         = 5,
  parameter int StartTimeoutCycles = 4000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [1:0]                      req,
  input  logic [13:0]                     reqAddress,
  input  logic [2*CountWidth-1:0]         reqSendCount,
  input  logic [2*MaxBytesToSend*8-1:0]   reqSendData,
  input  logic [2*CountWidth-1:0]         reqReadCount,
  output logic [1:0]                      done,
  output logic [3:0]                      status,
  output logic [2*MaxBytesToRead*8-1:0]   readData,
  output logic [1:0]                      busy,
  output logic                            masterStart,
  output logic [6:0]                      masterAddress,
  output logic [CountWidth-1:0]           masterNrOfBytesToSend,
  output logic [MaxBytesToSend*8-1:0]     masterBytesToSend,
  output logic [CountWidth-1:0]           masterNrOfBytesToRead,
  input  logic [MaxBytesToRead*8-1:0]     masterBytesToRead,
  input  logic                            masterReady,
  input  logic                            masterClockStretchTimeout
);

  localparam int SW = MaxBytesToSend * 8;
  localparam int RW = MaxBytesToRead * 8;
  localparam int TW = $clog2(StartTimeoutCycles + 1);
  localparam logic [CountWidth-1:0] MaxSend      = CountWidth'(MaxBytesToSend);
  localparam logic [CountWidth-1:0] MaxRead      = CountWidth'(MaxBytesToRead);
  localparam logic [TW-1:0]         TimeoutLimit = TW'(StartTimeoutCycles);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE} state_t;

  state_t                 state_q;
  logic [1:0]             req_q;
  logic [1:0]             pending_q;
  logic                   last_grant_q;
  logic                   grant_q;
  logic [TW-1:0]          timer_q;
  logic [1:0]             done_q;
  logic [3:0]             status_q;
  logic [2*RW-1:0]        read_data_q;
  logic                   m_start_q;
  logic [6:0]             m_addr_q;
  logic [CountWidth-1:0]  m_nsend_q;
  logic [SW-1:0]          m_send_q;
  logic [CountWidth-1:0]  m_nread_q;

  logic [1:0]             rise_d;
  logic [1:0]             grant_clr_d;
  logic                   winner_d;
  logic [CountWidth-1:0]  send_raw;
  logic [CountWidth-1:0]  read_raw;
  logic [CountWidth-1:0]  send_cnt_d;
  logic [CountWidth-1:0]  read_cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign busy[gi] = pending_q[gi] | ((state_q != IDLE) && (grant_q == 1'(gi)));
    end
  endgenerate

  assign rise_d = req & ~req_q & ~busy;

  always_comb begin
    // Tie goes to whoever was not served last.
    if (pending_q == 2'b11) winner_d = ~last_grant_q;
    else                    winner_d = pending_q[1] & ~pending_q[0];
    grant_clr_d = ((state_q == IDLE) && (|pending_q)) ? (2'b01 << winner_d) : 2'b00;
    send_raw    = winner_d ? reqSendCount[2*CountWidth-1:CountWidth] : reqSendCount[CountWidth-1:0];
    read_raw    = winner_d ? reqReadCount[2*CountWidth-1:CountWidth] : reqReadCount[CountWidth-1:0];
    send_cnt_d  = (send_raw > MaxSend) ? MaxSend : send_raw;
    read_cnt_d  = (read_raw > MaxRead) ? MaxRead : read_raw;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      pending_q    <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      timer_q      <= '0;
      done_q       <= '0;
      status_q     <= '0;
      read_data_q  <= '0;
      m_start_q    <= 1'b0;
      m_addr_q     <= '0;
      m_nsend_q    <= '0;
      m_send_q     <= '0;
      m_nread_q    <= '0;
    end else begin
      req_q     <= req;
      done_q    <= '0;
      pending_q <= (pending_q & ~grant_clr_d) | rise_d;
      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            grant_q   <= winner_d;
            m_addr_q  <= winner_d ? reqAddress[13:7] : reqAddress[6:0];
            m_nsend_q <= send_cnt_d;
            m_send_q  <= winner_d ? reqSendData[2*SW-1:SW] : reqSendData[SW-1:0];
            m_nread_q <= read_cnt_d;
            m_start_q <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          m_start_q <= 1'b0;
          timer_q   <= '0;
          state_q   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!masterReady) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == TimeoutLimit) begin
            status_q[{grant_q, 1'b0} +: 2] <= 2'b10;
            done_q[grant_q]                <= 1'b1;
            state_q                        <= COMPLETE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (masterReady) begin
            if (masterClockStretchTimeout) begin
              status_q[{grant_q, 1'b0} +: 2] <= 2'b01;
            end else begin
              status_q[{grant_q, 1'b0} +: 2] <= 2'b00;
              if (grant_q) read_data_q[2*RW-1:RW] <= masterBytesToRead;
              else         read_data_q[RW-1:0]    <= masterBytesToRead;
            end
            done_q[grant_q] <= 1'b1;
            state_q         <= COMPLETE;
          end
        end
        COMPLETE: begin
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done                  = done_q;
  assign status                = status_q;
  assign readData              = read_data_q;
  assign masterStart           = m_start_q;
  assign masterAddress         = m_addr_q;
  assign masterNrOfBytesToSend = m_nsend_q;
  assign masterBytesToSend     = m_send_q;
  assign masterNrOfBytesToRead = m_nread_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a behavioural I2C master that drops
// masterReady for a programmable number of cycles after each start strobe.
module tb_i2c_arbiter;
  localparam int CW = 5;
  localparam int SB = 16;
  localparam int RB = 16;
  localparam int TO = 4000;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [1:0]         req = '0;
  logic [13:0]        reqAddress = '0;
  logic [2*CW-1:0]    reqSendCount = '0;
  logic [2*CW-1:0]    reqReadCount = '0;
  logic [2*SB*8-1:0]  reqSendData = '0;
  logic [1:0]         done;
  logic [1:0]         busy;
  logic [3:0]         status;
  logic [2*RB*8-1:0]  readData;
  logic               masterStart;
  logic [6:0]         masterAddress;
  logic [CW-1:0]      masterNrOfBytesToSend;
  logic [CW-1:0]      masterNrOfBytesToRead;
  logic [SB*8-1:0]    masterBytesToSend;
  logic [RB*8-1:0]    masterBytesToRead = '0;
  logic               masterReady = 1'b1;
  logic               masterClockStretchTimeout = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  int start_cnt = 0;
  int done_cnt[2] = '{0, 0};
  int grant_log[$];
  int cyc = 0;
  int m_delay = 5;
  int m_cnt = 0;
  bit m_hang = 1'b0;

  i2c_arbiter #(
    .MaxBytesToSend(SB), .MaxBytesToRead(RB), .CountWidth(CW), .StartTimeoutCycles(TO)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .reqAddress(reqAddress),
    .reqSendCount(reqSendCount), .reqSendData(reqSendData), .reqReadCount(reqReadCount),
    .done(done), .status(status), .readData(readData), .busy(busy),
    .masterStart(masterStart), .masterAddress(masterAddress),
    .masterNrOfBytesToSend(masterNrOfBytesToSend), .masterBytesToSend(masterBytesToSend),
    .masterNrOfBytesToRead(masterNrOfBytesToRead), .masterBytesToRead(masterBytesToRead),
    .masterReady(masterReady), .masterClockStretchTimeout(masterClockStretchTimeout)
  );

  always #5 clock = ~clock;

  // Master model: goes busy on a start strobe, returns to ready after m_delay cycles.
  always @(posedge clock) begin
    if (reset) begin
      masterReady <= 1'b1;
    end else if (masterStart && !m_hang) begin
      masterReady <= 1'b0;
      m_cnt       <= m_delay;
    end else if (!masterReady) begin
      if (m_cnt <= 1) masterReady <= 1'b1;
      else            m_cnt <= m_cnt - 1;
    end
  end

  always @(negedge clock) begin
    cyc++;
    if (masterStart) start_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (done[i]) begin
        done_cnt[i]++;
        grant_log.push_back(i);
        $display("txn: requester %0d done status=%b cycle=%0d", i, status[2*i +: 2], cyc);
      end
    end
  end

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic pulse_req(input logic [1:0] m);
    req = req | m;
    tick();
    req = req & ~m;
  endtask

  task automatic wait_done_cnt(input int n, input int target, input int budget);
    int k = 0;
    while (done_cnt[n] < target && k < budget) begin
      tick();
      k++;
    end
    check_value("wait_done", 128'(done_cnt[n] >= target), 128'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  int base0, base1, c0;

  initial begin
    do_reset();
    check_value("rst_done", 128'(done), 128'd0);
    check_value("rst_busy", 128'(busy), 128'd0);
    check_value("rst_status", 128'(status), 128'd0);
    check_value("rst_readData", readData[127:0], 128'd0);
    check_value("rst_start", 128'(masterStart), 128'd0);
    check_value("rst_addr", 128'(masterAddress), 128'd0);

    // Basic read transaction on requester 0.
    reqAddress[6:0]    = 7'h68;
    reqSendCount[4:0]  = 5'd1;
    reqSendData[7:0]   = 8'h00;
    reqReadCount[4:0]  = 5'd7;
    masterBytesToRead  = 128'h00000000000000000007060504030201;
    m_delay            = 50;
    pulse_req(2'b01);
    check_value("lat_busy", 128'(busy), 128'd1);
    check_value("lat_start_lo", 128'(masterStart), 128'd0);
    tick();
    check_value("lat_start_hi", 128'(masterStart), 128'd1);
    check_value("t1_addr", 128'(masterAddress), 128'h68);
    check_value("t1_nsend", 128'(masterNrOfBytesToSend), 128'd1);
    check_value("t1_nread", 128'(masterNrOfBytesToRead), 128'd7);
    tick();
    check_value("t1_start_one", 128'(masterStart), 128'd0);
    wait_done_cnt(0, 1, 300);
    check_value("t1_status", 128'(status[1:0]), 128'd0);
    check_value("t1_rd0", readData[127:0], 128'h00000000000000000007060504030201);
    check_value("t1_addr_hold", 128'(masterAddress), 128'h68);
    tick();
    check_value("t1_done_width", 128'(done), 128'd0);
    check_value("t1_start_cnt", 128'(start_cnt), 128'd1);
    check_value("t1_done_cnt", 128'(done_cnt[0]), 128'd1);
    check_value("t1_rd1", readData[255:128], 128'd0);

    // Simultaneous requests, twice: expect 0,1,0,1.
    do_reset();
    grant_log.delete();
    base0 = done_cnt[0];
    base1 = done_cnt[1];
    m_delay = 5;
    reqAddress[13:7]  = 7'h11;
    masterBytesToRead = 128'h0000000000000000000000000000BEEF;
    for (int r = 0; r < 2; r++) begin
      pulse_req(2'b11);
      wait_done_cnt(1, base1 + r + 1, 300);
      tick();
    end
    check_value("tie_count", 128'(grant_log.size()), 128'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_value($sformatf("tie_order%0d", i), 128'(grant_log[i]), 128'(i % 2));
    check_value("tie_done0", 128'(done_cnt[0] - base0), 128'd2);
    check_value("tie_done1", 128'(done_cnt[1] - base1), 128'd2);
    check_value("tie_rd1", readData[255:128], 128'h0000000000000000000000000000BEEF);

    // Start timeout: master never leaves ready.
    m_hang = 1'b1;
    base0 = done_cnt[0];
    pulse_req(2'b01);
    tick();
    c0 = cyc;
    check_value("to_start", 128'(masterStart), 128'd1);
    wait_done_cnt(0, base0 + 1, TO + 100);
    check_value("to_latency", 128'(cyc - c0), 128'(TO + 2));
    check_value("to_status", 128'(status[1:0]), 128'b10);
    tick();
    m_hang = 1'b0;
    masterBytesToRead = 128'h000000000000000000000000000000A5;
    pulse_req(2'b01);
    wait_done_cnt(0, base0 + 2, 300);
    check_value("to_next_status", 128'(status[1:0]), 128'd0);
    check_value("to_next_rd", readData[127:0], 128'h000000000000000000000000000000A5);
    tick();

    // Clock-stretch timeout keeps old read data.
    masterBytesToRead = 128'h0000000000000000000000000000005A;
    masterClockStretchTimeout = 1'b1;
    pulse_req(2'b01);
    wait_done_cnt(0, base0 + 3, 300);
    check_value("cs_status", 128'(status[1:0]), 128'b01);
    check_value("cs_rd_keep", readData[127:0], 128'h000000000000000000000000000000A5);
    check_value("cs_status1", 128'(status[3:2]), 128'd0);
    tick();
    masterClockStretchTimeout = 1'b0;

    // Count saturation on requester 1, then an address-only probe on requester 0.
    base1 = done_cnt[1];
    reqAddress[13:7]   = 7'h22;
    reqSendCount[9:5]  = 5'd31;
    reqReadCount[9:5]  = 5'd20;
    pulse_req(2'b10);
    tick();
    check_value("clamp_addr", 128'(masterAddress), 128'h22);
    check_value("clamp_nsend", 128'(masterNrOfBytesToSend), 128'd16);
    check_value("clamp_nread", 128'(masterNrOfBytesToRead), 128'd16);
    wait_done_cnt(1, base1 + 1, 300);
    tick();
    reqSendCount[4:0] = 5'd0;
    reqReadCount[4:0] = 5'd0;
    pulse_req(2'b01);
    tick();
    check_value("zero_start", 128'(masterStart), 128'd1);
    check_value("zero_nsend", 128'(masterNrOfBytesToSend), 128'd0);
    check_value("zero_nread", 128'(masterNrOfBytesToRead), 128'd0);
    wait_done_cnt(0, base0 + 4, 300);
    check_value("zero_status", 128'(status[1:0]), 128'd0);
    tick();

    // Reset in WAIT_DONE aborts without a done pulse.
    m_delay = 50;
    pulse_req(2'b01);
    repeat (15) tick();
    base0 = done_cnt[0];
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_value("abort_start", 128'(masterStart), 128'd0);
    check_value("abort_busy", 128'(busy), 128'd0);
    check_value("abort_rd", readData, 128'd0);
    check_value("abort_done", 128'(done), 128'd0);
    repeat (60) tick();
    check_value("abort_no_done", 128'(done_cnt[0]), 128'(base0));
    m_delay = 5;
    masterBytesToRead = 128'h00000000000000000000000000000077;
    pulse_req(2'b01);
    wait_done_cnt(0, base0 + 1, 300);
    check_value("abort_next_status", 128'(status[1:0]), 128'd0);
    check_value("abort_next_rd", readData[127:0], 128'h00000000000000000000000000000077);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have exactly one clock, `clock`, and one reset, `reset`; reset is synchronous and active-high.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- MaxBytesToSend, 16, write payload capacity in bytes per requester.
- MaxBytesToRead, 16, read payload capacity in bytes per requester.
- CountWidth, 5, width of each byte-count field.
- StartTimeoutCycles, 4000, maximum number of cycles to wait for masterReady to fall after masterStart.

REQ-003 The block SHALL have the following ports (name, direction, width, meaning). Index n is 0 or 1; bit slice n of each packed bus belongs to requester n.
- clock, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- req, in, 2, per-requester request line; a rising edge requests one transaction.
- reqAddress, in, 2x7, 7-bit I2C address per requester.
- reqSendCount, in, 2xCountWidth, number of bytes to write.
- reqSendData, in, 2xMaxBytesToSend x8, write bytes; byte 0 is sent first.
- reqReadCount, in, 2xCountWidth, number of bytes to read.
- done, out, 2, one-cycle completion pulse per requester.
- status, out, 2x2, result of the last transaction: 00 ok, 01 clock-stretch timeout, 10 no-start.
- readData, out, 2xMaxBytesToRead x8, captured read bytes per requester.
- busy, out, 2, high while requester n is pending or granted.
- masterStart, out, 1, start strobe to the I2C master.
- masterAddress, out, 7, address forwarded to the master.
- masterNrOfBytesToSend, out, CountWidth, write byte count forwarded to the master.
- masterBytesToSend, out, MaxBytesToSend x8, write payload forwarded to the master.
- masterNrOfBytesToRead, out, CountWidth, read byte count forwarded to the master.
- masterBytesToRead, in, MaxBytesToRead x8, read payload returned by the master.
- masterReady, in, 1, master idle flag.
- masterClockStretchTimeout, in, 1, master clock-stretch timeout flag.

Function
REQ-004 Request detection:
- The block SHALL register `req`.
- A 0->1 transition on req[n] SHALL set pending[n].
- A rising edge on req[n] while busy[n]=1 SHALL be ignored.
- The requester SHALL hold its payload stable from the req rise until done[n].

REQ-005 The block SHALL implement the states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and COMPLETE.

REQ-006 In IDLE with any pending bit set:
- Select the winner g.
- Latch g and its payload into master-side registers.
- Clear pending[g].
- Go to ISSUE.

REQ-007 Arbitration:
- A single pending requester SHALL win.
- If both are pending, the requester not granted last SHALL win.
- lastGrant SHALL reset to 1, so requester 0 wins the first tie.

REQ-008 Count clamping:
- Counts above MaxBytesToSend or MaxBytesToRead SHALL be saturated to the maximum when latched.
- Zero counts SHALL be forwarded unchanged; an address-only probe is legal.

REQ-009 ISSUE SHALL assert masterStart for exactly one cycle and then go to WAIT_BUSY.

REQ-010 WAIT_BUSY SHALL:
- Go to WAIT_DONE on masterReady=0.
- Otherwise increment a cycle counter.
- On reaching StartTimeoutCycles, set status[g]=10 and go to COMPLETE.

REQ-011 WAIT_DONE SHALL, on masterReady=1:
- If masterClockStretchTimeout=1: set status[g]=01, leave readData[g] unchanged, go to COMPLETE.
- Otherwise: copy masterBytesToRead into readData[g], set status[g]=00, go to COMPLETE.

REQ-012 COMPLETE SHALL:
- Pulse done[g] high for one cycle.
- Update lastGrant.
- Go to IDLE.

REQ-013 The non-granted requester's readData and status SHALL never change during another requester's transaction.

REQ-014 All master-side outputs SHALL remain constant from ISSUE through COMPLETE.

REQ-015 Latency with the master idle:
- Req rise sampled at edge E sets pending at E.
- ISSUE begins at E+1.
- masterStart is high during cycle E+1..E+2.

REQ-016 A req edge arriving during another transaction SHALL stay pending and be served at the next IDLE.

Reset
REQ-017 Reset SHALL set the following, regardless of current state, including mid-transaction:
- state = IDLE
- pending = 0
- lastGrant = 1
- all counters = 0
- done = 0, busy = 0, status = 00 for both requesters
- readData = 0
- masterStart = 0
- all master-side outputs = 0

REQ-018 A transaction aborted by reset SHALL produce no done pulse.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Req0 rise with address 0x68, send 1 byte 0x00, read 7; master model drops ready for 50 cycles and returns bytes 0x01..0x07 -> exactly one masterStart pulse; masterAddress=0x68; done[0] one cycle; status[0]=00; readData[0] bytes 0..6 = 0x01..0x07; readData[1] stays 0.
- req0 and req1 rise in the same cycle, repeated twice -> order of grants is 0, 1, 0, 1; each requester gets exactly one done per request.
- Master holds ready=1 forever -> after StartTimeoutCycles+1 cycles in WAIT_BUSY, done[0] pulses with status[0]=10; the next request still proceeds.
- masterClockStretchTimeout=1 when ready returns -> status=01; readData keeps its previous value.
- reqSendCount=31 with MaxBytesToSend=16 -> masterNrOfBytesToSend=16; both counts 0 -> transaction still issued and done with status 00.
- Reset asserted while in WAIT_DONE -> next cycle: masterStart=0, busy=00, readData=0, no done pulse; a fresh req0 edge is then served normally.
